// File: rtl/round_referee.sv
// Round controller and judge for rock-paper-scissors: captures moves on a button press,
// scores the round and publishes {ai, player} history. Optional debounce: REFEREE_DEBOUNCE_EN.
module round_referee #(
   parameter int unsigned WIN_SCORE       = 5,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       key_n,
   input  logic [1:0] player_move,
   input  logic [1:0] ai_choice,
   output logic [3:0] combination,
   output logic       comb_valid,
   output logic [1:0] result,
   output logic [3:0] player_score,
   output logic [3:0] ai_score,
   output logic [7:0] round_count,
   output logic       move_err,
   output logic       game_over
);

   if (WIN_SCORE < 1 || WIN_SCORE > 9 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("round_referee: parameter out of range");
   end

   localparam logic [3:0] WIN = 4'(WIN_SCORE);

   localparam logic [1:0] RES_TIE    = 2'b00;
   localparam logic [1:0] RES_PLAYER = 2'b01;
   localparam logic [1:0] RES_AI     = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      JUDGE,
      PUBLISH,
      GAMEOVER
   } state_t;

   state_t state, state_nxt;

   logic       sync_1, sync_2;
   logic       press_evt;
   logic       capture, illegal;
   logic [1:0] p, a;
   logic [1:0] a_next;
   logic [1:0] outcome;

   always_ff @(posedge clock) begin
      if (!reset) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
      end else begin
         sync_1 <= key_n;
         sync_2 <= sync_1;
      end
   end

`ifdef REFEREE_DEBOUNCE_EN
   localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [DB_W-1:0] db_count;
   logic            db_level;

   // db_level is the accepted key level; it flips only after DEBOUNCE_CYCLES
   // consecutive samples disagree with it, in either direction.
   always_ff @(posedge clock) begin
      if (!reset) begin
         db_count <= '0;
         db_level <= 1'b1;
      end else if (sync_2 == db_level) begin
         db_count <= '0;
      end else if (db_count == DB_LAST) begin
         db_count <= '0;
         db_level <= sync_2;
      end else begin
         db_count <= db_count + 1'b1;
      end
   end

   always_comb begin
      press_evt = db_level && !sync_2 && (db_count == DB_LAST);
   end
`else
   logic key_prev;

   always_ff @(posedge clock) begin
      if (!reset) begin
         key_prev <= 1'b1;
      end else begin
         key_prev <= sync_2;
      end
   end

   always_comb begin
      press_evt = key_prev && !sync_2;
   end
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      illegal   = 1'b0;
      case (state)
         IDLE: begin
            if (press_evt) begin
               if (player_move == 2'd3) begin
                  illegal = 1'b1;
               end else begin
                  capture   = 1'b1;
                  state_nxt = JUDGE;
               end
            end
         end
         JUDGE:    state_nxt = PUBLISH;
         PUBLISH:  state_nxt = (player_score == WIN || ai_score == WIN) ? GAMEOVER : IDLE;
         GAMEOVER: state_nxt = GAMEOVER;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      a_next = (a == 2'd2) ? 2'd0 : a + 2'd1;
      if (p == a) begin
         outcome = RES_TIE;
      end else if (p == a_next) begin
         outcome = RES_PLAYER;
      end else begin
         outcome = RES_AI;
      end
   end

   // The PUBLISH-cycle outputs (combination, comb_valid, round_count) are
   // registered on the JUDGE->PUBLISH edge so they are stable during PUBLISH.
   always_ff @(posedge clock) begin
      if (!reset) begin
         p            <= '0;
         a            <= '0;
         combination  <= '0;
         comb_valid   <= 1'b0;
         result       <= RES_TIE;
         player_score <= '0;
         ai_score     <= '0;
         round_count  <= '0;
         move_err     <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         move_err   <= illegal;
         comb_valid <= (state == JUDGE);
         game_over  <= (state_nxt == GAMEOVER);
         if (capture) begin
            p <= player_move;
            a <= ai_choice;
         end
         if (state == JUDGE) begin
            result      <= outcome;
            combination <= {a, p};
            round_count <= round_count + 8'd1;
            if (outcome == RES_PLAYER && player_score != WIN) begin
               player_score <= player_score + 4'd1;
            end
            if (outcome == RES_AI && ai_score != WIN) begin
               ai_score <= ai_score + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_round_referee.sv
// Self-checking bench for round_referee: directed plan plus randomized rounds
// against a score/round model kept in plain integers.
module tb_round_referee;

   localparam int W = 5;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       key_n = 1'b1;
   logic [1:0] player_move = 2'd0;
   logic [1:0] ai_choice = 2'd0;
   logic [3:0] combination;
   logic       comb_valid;
   logic [1:0] result;
   logic [3:0] player_score;
   logic [3:0] ai_score;
   logic [7:0] round_count;
   logic       move_err;
   logic       game_over;

   round_referee #(.WIN_SCORE(W), .DEBOUNCE_CYCLES(16)) dut (
      .clock(clock), .reset(reset), .key_n(key_n),
      .player_move(player_move), .ai_choice(ai_choice),
      .combination(combination), .comb_valid(comb_valid), .result(result),
      .player_score(player_score), .ai_score(ai_score), .round_count(round_count),
      .move_err(move_err), .game_over(game_over)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   int cyc, cv_count, me_count, cv_cycle, go_cycle;

   int       m_ps, m_as, m_rc, m_res;
   int       m_comb;
   bit       m_over;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
      if (comb_valid === 1'b1) begin
         cv_count++;
         if (cv_count == 1) cv_cycle = cyc;
      end
      if (move_err === 1'b1) me_count++;
      if (game_over === 1'b1 && go_cycle < 0) go_cycle = cyc;
   endtask

   task automatic press(input logic [1:0] pm, input logic [1:0] am, input int low_cycles,
                        input int rel_cycles, input bit scramble);
      cyc = 0; cv_count = 0; me_count = 0; cv_cycle = -1; go_cycle = -1;
      player_move = pm;
      ai_choice   = am;
      key_n       = 1'b0;
      for (int i = 0; i < low_cycles; i++) begin
         step();
         if (scramble && i == 3) begin
            player_move = 2'($urandom_range(0, 3));
            ai_choice   = 2'($urandom_range(0, 3));
         end
      end
      key_n = 1'b1;
      repeat (rel_cycles) step();
   endtask

   task automatic model_clear();
      m_ps = 0; m_as = 0; m_rc = 0; m_res = 0; m_comb = 0; m_over = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      key_n = 1'b1;
      step();
      step();
      reset = 1'b1;
      step();
      model_clear();
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".combination"}, 32'(combination), 32'(m_comb));
      check({tag, ".result"}, 32'(result), 32'(m_res));
      check({tag, ".player_score"}, 32'(player_score), 32'(m_ps));
      check({tag, ".ai_score"}, 32'(ai_score), 32'(m_as));
      check({tag, ".round_count"}, 32'(round_count), 32'(m_rc));
      check({tag, ".game_over"}, 32'(game_over), 32'(m_over));
   endtask

   // One press, predicted by the rules: (p - a) mod 3 == 1 player wins, == 2 AI wins.
   task automatic do_round(input string tag, input logic [1:0] pm, input logic [1:0] am,
                           input bit scramble);
      int exp_cv, exp_me, d;
      bit was_over, ended;
      was_over = m_over;
      ended = 1'b0;
      exp_cv = 0;
      exp_me = 0;
      if (m_over) begin
         exp_cv = 0;
      end else if (pm == 2'd3) begin
         exp_me = 1;
      end else begin
         exp_cv = 1;
         d = (int'(pm) - int'(am) + 3) % 3;
         m_res = d;
         if (d == 1 && m_ps < W) m_ps++;
         if (d == 2 && m_as < W) m_as++;
         m_comb = int'(am) * 4 + int'(pm);
         m_rc = (m_rc + 1) % 256;
         if (m_ps == W || m_as == W) begin
            m_over = 1'b1;
            ended = 1'b1;
         end
      end
      press(pm, am, 6, 8, scramble);
      check({tag, ".comb_valid_count"}, 32'(cv_count), 32'(exp_cv));
      check({tag, ".move_err_count"}, 32'(me_count), 32'(exp_me));
      check_outputs(tag);
`ifndef REFEREE_DEBOUNCE_EN
      if (exp_cv == 1) check({tag, ".latency"}, 32'(cv_cycle), 32'd4);
`endif
      if (ended && !was_over) check({tag, ".game_over_cycle"}, 32'(go_cycle), 32'(cv_cycle + 1));
   endtask

   initial begin
      int total_cv;
      model_clear();

      // Reset state
      repeat (3) step();
      check("reset.comb_valid", 32'(comb_valid), 32'd0);
      check("reset.move_err", 32'(move_err), 32'd0);
      check_outputs("reset");
      reset = 1'b1;
      step();

      // Directed rounds
      do_round("win", 2'd1, 2'd0, 1'b0);
      do_round("tie", 2'd2, 2'd2, 1'b0);
      do_round("illegal", 2'd3, 2'd0, 1'b0);
      for (int i = 0; i < 5; i++) do_round("ai_win", 2'd0, 2'd1, 1'b0);
      do_round("after_over", 2'd0, 2'd1, 1'b0);
      do_round("after_over_illegal", 2'd3, 2'd1, 1'b0);

      // Reset while the round is in JUDGE
      do_reset();
      cyc = 0; cv_count = 0; me_count = 0; cv_cycle = -1; go_cycle = -1;
      player_move = 2'd1;
      ai_choice   = 2'd0;
      key_n       = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      key_n = 1'b1;
      step();
      check("mid_reset.comb_valid", 32'(comb_valid), 32'd0);
      check("mid_reset.move_err", 32'(move_err), 32'd0);
      check_outputs("mid_reset");
      reset = 1'b1;
      repeat (10) step();
      check("mid_reset.no_publish", 32'(cv_count), 32'd0);
      do_round("post_reset", 2'd1, 2'd2, 1'b0);

      // Randomized rounds, ai_choice/player_move scrambled after capture
      do_reset();
      for (int i = 0; i < 60; i++) begin
         do_round("rand", 2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), 1'b1);
         if (m_over && $urandom_range(0, 2) == 0) do_reset();
      end

      // Short glitches followed by one long press
      do_reset();
      total_cv = 0;
      for (int i = 0; i < 3; i++) begin
         press(2'd2, 2'd2, 5, 40, 1'b0);
         total_cv += cv_count;
      end
      press(2'd2, 2'd2, 20, 40, 1'b0);
      total_cv += cv_count;
`ifdef REFEREE_DEBOUNCE_EN
      check("glitch.rounds", 32'(total_cv), 32'd1);
      check("glitch.round_count", 32'(round_count), 32'd1);
`else
      check("glitch.rounds", 32'(total_cv), 32'd4);
      check("glitch.round_count", 32'(round_count), 32'd4);
`endif
      check("glitch.combination", 32'(combination), 32'hA);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
